sr_cmd_conditioner: RTL and testbench
=====================================

// Module: sr_cmd_conditioner
// PURPOSE
//  Upstream command stage for the SR flip-flop bank. Takes raw asynchronous set/clear
//  request levels, synchronises and debounces them, and resolves conflicts. Emits
//  registered one-cycle s/r pulses that never assert together, so downstream SR flops
//  never take the invalid 11 code. Tracks the expected flop state in q_shadow.
// PARAMETERS
//  DEBOUNCE  4  consecutive stable synchronised cycles required to qualify a request (>=1)
//  HOLDOFF   2  busy cycles after a command or conflict before release is checked (>=0)
//  CNT_W     8  width of conflict_cnt
// PORTS
//  clk           in   1      rising-edge clock
//  rst_n         in   1      asynchronous active-low reset
//  set_req       in   1      raw set request level, asynchronous
//  clr_req       in   1      raw clear request level, asynchronous
//  s             out  1      one-cycle set pulse to downstream SR flop
//  r             out  1      one-cycle reset pulse to downstream SR flop
//  q_shadow      out  1      expected downstream q after issued commands
//  busy          out  1      high whenever state != IDLE
//  conflict      out  1      one-cycle pulse: stable 11 request qualified
//  conflict_cnt  out  CNT_W  saturating conflict count (see CONFIGURATION)
// BEHAVIOUR
//  - rst_n low: state=IDLE; s=r=q_shadow=busy=conflict=0; conflict_cnt=0; sync FFs=0.
//    Reset asserted mid-operation aborts immediately. s/r are registered and cannot glitch.
//  - 2-FF synchroniser on each request gives code = {set_sync, clr_sync}.
//  - The stability counter clears on any code change and increments while code is stable.
//  - FSM states: IDLE, QUAL, ISSUE, HOLD, WAIT_REL.
//    IDLE:     code!=00 -> QUAL (counter=0).
//    QUAL:     code->00 -> IDLE; code changed to other nonzero -> stay, counter=0.
//              Stable for DEBOUNCE cycles: code 10/01 -> ISSUE; code 11 -> conflict pulse, HOLD.
//    ISSUE:    exactly 1 cycle. 10: s=1 unless q_shadow==1 (redundant, suppressed).
//              01: r=1 unless q_shadow==0. q_shadow updates at the end of this cycle.
//              Then go to HOLD.
//    HOLD:     HOLDOFF cycles. With HOLDOFF=0, go straight to WAIT_REL.
//    WAIT_REL: stay until code==00, then IDLE. Each assertion yields at most one command.
//  - Latency: the first edge sampling stable set_req high is edge 0; s is high after edge
//    DEBOUNCE+2 and low one cycle later.
//  - s and r are never both 1. conflict never coincides with s or r.
//  - A request that drops before qualifying produces no pulse.
//  - Switching 10->01 during QUAL restarts qualification for 01.
// CONFIGURATION
//  SR_CONFLICT_CNT_EN defined:
//    conflict_cnt increments on each conflict pulse and saturates at 2^CNT_W-1.
//    It clears only on reset.
//  Undefined: no counter logic; conflict_cnt is tied to 0. The conflict pulse is unaffected.
// TESTING
//  1. Reset release, requests 0 -> all outputs 0 for 20 cycles, busy=0.
//  2. DEBOUNCE=4, set_req held high 20 cycles -> single s pulse at edge 6,
//     q_shadow 0->1, busy until release + 1.
//  3. set_req high 3 cycles then low -> no s/r; FSM returns to IDLE; busy drops.
//  4. set_req and clr_req both high 10 cycles -> conflict pulse once, s=r=0 throughout;
//     with SR_CONFLICT_CNT_EN, conflict_cnt=1.
//  5. q_shadow=1, set_req pulse again -> no s (suppressed); then clr_req -> one r pulse,
//     q_shadow=0.
//  6. rst_n low during ISSUE cycle -> s=0 at once, q_shadow=0; no pulse after rst_n rises.

Source files
------------

// File: rtl/sr_cmd_if.sv
// sr_cmd_if: request inputs and command/status outputs of the SR command
// conditioner, bundled so the requester and the conditioner share one port.
interface sr_cmd_if #(
  parameter int CNT_W = 8
);
  logic             set_req;
  logic             clr_req;
  logic             s;
  logic             r;
  logic             q_shadow;
  logic             busy;
  logic             conflict;
  logic [CNT_W-1:0] conflict_cnt;

  // Requester side: drives raw request levels, observes commands and status.
  modport master (
    output set_req, clr_req,
    input  s, r, q_shadow, busy, conflict, conflict_cnt
  );

  // Conditioner side.
  modport slave (
    input  set_req, clr_req,
    output s, r, q_shadow, busy, conflict, conflict_cnt
  );
endinterface

// File: rtl/sr_cmd_conditioner.sv
// sr_cmd_conditioner: synchronises and debounces raw set/clear request levels
// and issues one-cycle s/r pulses that never overlap, tracking the expected
// downstream flop state in q_shadow. A stable 11 request raises a one-cycle
// conflict pulse instead of a command.
// Optional feature macro: SR_CONFLICT_CNT_EN enables the saturating
// conflict counter; without it conflict_cnt is tied to zero.
module sr_cmd_conditioner #(
  parameter int DEBOUNCE = 4,
  parameter int HOLDOFF  = 2,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  sr_cmd_if.slave     cmd_if
);

  localparam int SC_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int HC_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [SC_W-1:0] STAB_LAST = SC_W'(DEBOUNCE - 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    QUAL     = 3'd1,
    ISSUE    = 3'd2,
    HOLD     = 3'd3,
    WAIT_REL = 3'd4
  } state_t;

  state_t          r_state;
  logic            r_set_meta;
  logic            r_set_sync;
  logic            r_clr_meta;
  logic            r_clr_sync;
  logic [1:0]      r_code_q;
  logic [SC_W-1:0] r_stab_cnt;
  logic [HC_W-1:0] r_hold_cnt;
  logic            r_cmd_set;
  logic            r_s;
  logic            r_r;
  logic            r_q_shadow;
  logic            r_conflict;

  logic [1:0]      w_code;
  logic            w_change;
  logic            w_stable_done;

  assign w_code        = {r_set_sync, r_clr_sync};
  assign w_change      = (w_code != r_code_q);
  assign w_stable_done = !w_change && (r_stab_cnt == STAB_LAST);

  // Two-flop synchronisers on both asynchronous request levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_set_meta <= 1'b0;
      r_set_sync <= 1'b0;
      r_clr_meta <= 1'b0;
      r_clr_sync <= 1'b0;
    end else begin
      r_set_meta <= cmd_if.set_req;
      r_set_sync <= r_set_meta;
      r_clr_meta <= cmd_if.clr_req;
      r_clr_sync <= r_clr_meta;
    end
  end

  // Stability counter: cleared on any code change, counts up (saturating) while stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code_q   <= 2'b00;
      r_stab_cnt <= '0;
    end else begin
      r_code_q <= w_code;
      if (w_change) begin
        r_stab_cnt <= '0;
      end else if (r_stab_cnt != STAB_LAST) begin
        r_stab_cnt <= r_stab_cnt + 1'b1;
      end
    end
  end

  // Command FSM with registered s/r/conflict pulses and shadow state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_cmd_set  <= 1'b0;
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_q_shadow <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_conflict <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_code != 2'b00) r_state <= QUAL;
        end
        QUAL: begin
          if (w_code == 2'b00) begin
            r_state <= IDLE;
          end else if (w_stable_done) begin
            r_hold_cnt <= '0;
            if (w_code == 2'b11) begin
              r_conflict <= 1'b1;
              r_state    <= (HOLDOFF == 0) ? WAIT_REL : HOLD;
            end else begin
              // A command matching the current shadow state is redundant and suppressed.
              r_cmd_set <= w_code[1];
              r_s       <= w_code[1] && !r_q_shadow;
              r_r       <= w_code[0] && r_q_shadow;
              r_state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          r_q_shadow <= r_cmd_set;
          r_hold_cnt <= '0;
          r_state    <= (HOLDOFF == 0) ? WAIT_REL : HOLD;
        end
        HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_state <= WAIT_REL;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        WAIT_REL: begin
          if (w_code == 2'b00) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SR_CONFLICT_CNT_EN
  logic [CNT_W-1:0] r_conflict_cnt;

  // Saturating count of conflict pulses; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= '0;
    end else if (r_conflict && (r_conflict_cnt != {CNT_W{1'b1}})) begin
      r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  assign cmd_if.conflict_cnt = r_conflict_cnt;
`else
  assign cmd_if.conflict_cnt = '0;
`endif

  assign cmd_if.s        = r_s;
  assign cmd_if.r        = r_r;
  assign cmd_if.q_shadow = r_q_shadow;
  assign cmd_if.conflict = r_conflict;
  assign cmd_if.busy     = (r_state != IDLE);

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// tb_sr_cmd_conditioner: directed stimulus for sr_cmd_conditioner. Expected
// s/r/conflict pulses (kind and cycle) are queued when a request is driven;
// a negedge monitor pops and compares whenever the DUT emits a pulse.
module tb_sr_cmd_conditioner;
  localparam int DB = 4;
  localparam int HO = 2;
  localparam int CW = 8;
`ifdef SR_CONFLICT_CNT_EN
  localparam int CNT_EXP = 1;
`else
  localparam int CNT_EXP = 0;
`endif

  localparam logic [2:0] K_S = 3'b100;
  localparam logic [2:0] K_R = 3'b010;
  localparam logic [2:0] K_C = 3'b001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sr_cmd_if #(.CNT_W(CW)) bus ();

  sr_cmd_conditioner #(
    .DEBOUNCE(DB),
    .HOLDOFF (HO),
    .CNT_W   (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cmd_if(bus)
  );

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] at;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
    end
  endtask

  // Called right after a negedge when the request is driven: edge 0 is the
  // next rising edge, and the pulse is visible after edge DB+2.
  task automatic expect_pulse(input logic [2:0] kind);
    ev_t e;
    e.kind = kind;
    e.at   = 32'(cyc + 1 + DB + 2);
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every emitted pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n && (bus.s || bus.r || bus.conflict)) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse: got s/r/conflict=%b at cycle %0d, required none",
                 {bus.s, bus.r, bus.conflict}, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_kind", int'({bus.s, bus.r, bus.conflict}), int'(mon_e.kind));
        check("pulse_cycle", cyc, int'(mon_e.at));
      end
    end
  end

  initial begin
    bus.set_req = 1'b0;
    bus.clr_req = 1'b0;

    // 1. Reset state and quiet idle
    tick(2);
    check("rst_s", int'(bus.s), 0);
    check("rst_r", int'(bus.r), 0);
    check("rst_q_shadow", int'(bus.q_shadow), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_conflict_cnt", int'(bus.conflict_cnt), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (i % 5 == 4) begin
        check("idle_busy", int'(bus.busy), 0);
        check("idle_q_shadow", int'(bus.q_shadow), 0);
      end
    end

    // 2. Held set request -> single s pulse after edge DB+2
    expect_pulse(K_S);
    bus.set_req = 1'b1;
    tick(2);
    check("set_busy_pre", int'(bus.busy), 0);
    tick(1);
    check("set_busy_qual", int'(bus.busy), 1);
    tick(17);
    check("set_q_shadow", int'(bus.q_shadow), 1);
    check("set_busy_wait", int'(bus.busy), 1);
    bus.set_req = 1'b0;
    tick(2);
    check("set_busy_release", int'(bus.busy), 1);
    tick(1);
    check("set_busy_idle", int'(bus.busy), 0);

    // 3. Short request drops before qualifying -> no pulse
    tick(2);
    bus.set_req = 1'b1;
    tick(3);
    check("short_busy", int'(bus.busy), 1);
    bus.set_req = 1'b0;
    tick(10);
    check("short_busy_idle", int'(bus.busy), 0);
    check("short_q_shadow", int'(bus.q_shadow), 1);

    // 4. Both requests high -> one conflict pulse, no s/r
    expect_pulse(K_C);
    bus.set_req = 1'b1;
    bus.clr_req = 1'b1;
    tick(10);
    bus.set_req = 1'b0;
    bus.clr_req = 1'b0;
    tick(6);
    check("conflict_cnt", int'(bus.conflict_cnt), CNT_EXP);
    check("conflict_busy_idle", int'(bus.busy), 0);
    check("conflict_q_shadow", int'(bus.q_shadow), 1);

    // 5. Redundant set suppressed, then clear issues one r pulse
    bus.set_req = 1'b1;
    tick(10);
    bus.set_req = 1'b0;
    tick(6);
    check("redundant_q_shadow", int'(bus.q_shadow), 1);
    check("redundant_busy_idle", int'(bus.busy), 0);
    expect_pulse(K_R);
    bus.clr_req = 1'b1;
    tick(10);
    bus.clr_req = 1'b0;
    tick(6);
    check("clr_q_shadow", int'(bus.q_shadow), 0);
    check("clr_busy_idle", int'(bus.busy), 0);

    // 6. Reset during ISSUE aborts the pulse immediately
    bus.set_req = 1'b1;
    tick(6);
    @(posedge clk);
    #1;
    check("issue_s_high", int'(bus.s), 1);
    rst_n = 1'b0;
    bus.set_req = 1'b0;
    #1;
    check("abort_s", int'(bus.s), 0);
    check("abort_q_shadow", int'(bus.q_shadow), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_conflict_cnt", int'(bus.conflict_cnt), 0);
    tick(3);
    rst_n = 1'b1;
    tick(20);
    check("post_rst_busy", int'(bus.busy), 0);
    check("post_rst_q_shadow", int'(bus.q_shadow), 0);

    // Any expected pulse never seen is a miscompare.
    while (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_pulse: got none, required kind %b at cycle %0d",
               mon_e.kind, mon_e.at);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
